// File: rtl/exibe_jogada.sv
// Timed playback of one move on the RGB LED: show the latched one-hot code for
// T_ON cycles, blank for T_OFF cycles, then pulse fim for one cycle.
module exibe_jogada #(
  parameter int T_ON  = 500,
  parameter int T_OFF = 250,
  parameter int CW    = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] codigo_in,
  output logic [3:0] codigo_out,
  output logic       ocupado,
  output logic       fim,
  output logic       rejeitado
);

  localparam logic [1:0] OCIOSO  = 2'd0;
  localparam logic [1:0] ACESO   = 2'd1;
  localparam logic [1:0] APAGADO = 2'd2;
  localparam logic [1:0] FIM     = 2'd3;

  localparam logic [CW-1:0] ON_ULTIMO  = CW'(T_ON - 1);
  localparam logic [CW-1:0] OFF_ULTIMO = (T_OFF > 0) ? CW'(T_OFF - 1) : '0;

  logic [1:0]    r_estado;
  logic [1:0]    w_prox_estado;
  logic [CW-1:0] r_contador;
  logic [3:0]    r_codigo;
  logic          r_rejeitado;
  logic          w_valido;
  logic          w_aceita;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign w_valido = (codigo_in != 4'b0000) && ((codigo_in & (codigo_in - 4'd1)) == 4'b0000);
  assign w_aceita = (r_estado == OCIOSO) && iniciar && w_valido;

  always_comb begin
    // NOTE: default first so every path assigns w_prox_estado and no latch is inferred.
    w_prox_estado = r_estado;
    case (r_estado)
      OCIOSO:  if (w_aceita) w_prox_estado = ACESO;
      ACESO:   if (r_contador == ON_ULTIMO) w_prox_estado = (T_OFF > 0) ? APAGADO : FIM;
      APAGADO: if (r_contador == OFF_ULTIMO) w_prox_estado = FIM;
      FIM:     w_prox_estado = OCIOSO;
      default: w_prox_estado = OCIOSO;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado    <= OCIOSO;
      r_contador  <= '0;
      r_codigo    <= 4'b0000;
      r_rejeitado <= 1'b0;
    end else begin
      r_estado    <= w_prox_estado;
      r_rejeitado <= (r_estado == OCIOSO) && iniciar && !w_valido;
      // Counter restarts on every state change, so it never needs to wrap.
      if (r_estado == OCIOSO || w_prox_estado != r_estado)
        r_contador <= '0;
      else
        r_contador <= r_contador + CW'(1);
      if (w_aceita)
        r_codigo <= codigo_in;
    end
  end

  assign codigo_out = (r_estado == ACESO) ? r_codigo : 4'b0000;
  assign ocupado    = (r_estado == ACESO) || (r_estado == APAGADO);
  assign fim        = (r_estado == FIM);
  assign rejeitado  = r_rejeitado;

endmodule

// File: tb/tb_exibe_jogada.sv
// Directed bench for exibe_jogada: T_ON=4/T_OFF=2 instance plus a T_OFF=0 instance.
module tb_exibe_jogada;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic       iniciar_b;
  logic [3:0] codigo_in;
  logic [3:0] codigo_out, codigo_out_b;
  logic       ocupado, ocupado_b;
  logic       fim, fim_b;
  logic       rejeitado, rejeitado_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  exibe_jogada #(.T_ON(4), .T_OFF(2), .CW(8)) dut_a (
    .clock(clock), .reset(reset), .iniciar(iniciar), .codigo_in(codigo_in),
    .codigo_out(codigo_out), .ocupado(ocupado), .fim(fim), .rejeitado(rejeitado)
  );

  exibe_jogada #(.T_ON(4), .T_OFF(0), .CW(8)) dut_b (
    .clock(clock), .reset(reset), .iniciar(iniciar_b), .codigo_in(codigo_in),
    .codigo_out(codigo_out_b), .ocupado(ocupado_b), .fim(fim_b), .rejeitado(rejeitado_b)
  );

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Compares {codigo_out, ocupado, fim, rejeitado}.
  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got cod=%b ocu=%b fim=%b rej=%b, expected cod=%b ocu=%b fim=%b rej=%b",
             tag, got[6:3], got[2], got[1], got[0], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [6:0] out_a();
    return {codigo_out, ocupado, fim, rejeitado};
  endfunction

  function automatic logic [6:0] out_b();
    return {codigo_out_b, ocupado_b, fim_b, rejeitado_b};
  endfunction

  // Expected DUT A outputs on cycle c after the accepting edge (T_ON=4, T_OFF=2).
  function automatic logic [6:0] exp_move(input int c, input logic [3:0] code);
    if (c >= 1 && c <= 4) return {code, 3'b100};
    if (c == 5 || c == 6) return {4'b0000, 3'b100};
    if (c == 7)           return {4'b0000, 3'b010};
    return 7'b0000000;
  endfunction

  localparam logic [6:0] IDLE = 7'b0000000;
  localparam logic [6:0] REJ  = 7'b0000001;

  initial begin
    reset = 1'b1; iniciar = 1'b0; iniciar_b = 1'b0; codigo_in = 4'b0000;

    // Reset then idle
    tick(); check("reset_c1", out_a(), IDLE);
    tick(); check("reset_c2", out_a(), IDLE);
    reset = 1'b0;
    tick(); check("idle_c1", out_a(), IDLE);
    tick(); check("idle_c2", out_a(), IDLE);
    check("idle_b", out_b(), IDLE);

    // Single move with 0100
    codigo_in = 4'b0100; iniciar = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      iniciar = 1'b0;
      check($sformatf("single_c%0d", c), out_a(), exp_move(c, 4'b0100));
    end

    // Invalid codes: multi-hot then zero
    codigo_in = 4'b0110; iniciar = 1'b1;
    tick(); iniciar = 1'b0;
    check("inval_0110_c1", out_a(), REJ);
    tick(); check("inval_0110_c2", out_a(), IDLE);
    codigo_in = 4'b0000; iniciar = 1'b1;
    tick(); iniciar = 1'b0;
    check("inval_0000_c1", out_a(), REJ);
    tick(); check("inval_0000_c2", out_a(), IDLE);

    // Input change while held start: 1000 shown, then 0001 after one idle cycle
    codigo_in = 4'b1000; iniciar = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 2) codigo_in = 4'b0001;
      if (c == 9) iniciar = 1'b0;
      if (c <= 8)
        check($sformatf("held_c%0d", c), out_a(), exp_move(c, 4'b1000));
      else
        check($sformatf("held_c%0d", c), out_a(), exp_move(c - 8, 4'b0001));
    end

    // Reset mid-ACESO, then a fresh move with full timing
    codigo_in = 4'b0010; iniciar = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      iniciar = 1'b0;
      check($sformatf("midrst_c%0d", c), out_a(), exp_move(c, 4'b0010));
    end
    reset = 1'b1;
    tick(); check("midrst_reset", out_a(), IDLE);
    reset = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick(); check($sformatf("midrst_after_c%0d", c), out_a(), IDLE);
    end
    codigo_in = 4'b0001; iniciar = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      iniciar = 1'b0;
      check($sformatf("fresh_c%0d", c), out_a(), exp_move(c, 4'b0001));
    end

    // T_OFF=0 instance: 4 on cycles, fim on cycle 5, no blank
    codigo_in = 4'b0010; iniciar_b = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      iniciar_b = 1'b0;
      if (c <= 4)      check($sformatf("toff0_c%0d", c), out_b(), {4'b0010, 3'b100});
      else if (c == 5) check("toff0_c5", out_b(), 7'b0000010);
      else             check("toff0_c6", out_b(), IDLE);
    end
    check("toff0_a_quiet", out_a(), IDLE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/exibe_jogada.md
Name: exibe_jogada

Overview:
- Timed display controller directly upstream of the one-hot-to-RGB LED colour converter.
- On a start pulse, latches a 4-bit one-hot button code and drives it to the converter for a fixed on-time, then blanks it for a fixed gap, then pulses completion.
- Used by the game FSM to play back stored sequence moves one at a time on the RGB LED.

Parameters:
- T_ON, 500, cycles the code is shown; must be >= 1.
- T_OFF, 250, cycles of blank gap after the on-time; 0 allowed, meaning no gap.
- CW, 16, counter width; must satisfy 2^CW > max(T_ON, T_OFF).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- iniciar  in  1  start request, sampled on rising edge.
- codigo_in  in  4  one-hot move code: bit3 green, bit2 yellow, bit1 blue, bit0 red.
- codigo_out  out  4  code fed to the colour converter; 4'b0000 means LED off.
- ocupado  out  1  high while a display cycle is in progress.
- fim  out  1  one-cycle completion pulse.
- rejeitado  out  1  one-cycle pulse when a start is refused because the code is invalid.

Behaviour:
- Interface: one clock (clock). Reset (reset) is synchronous and active-high: sampled only on the rising edge of clock.
- Reset: state OCIOSO, counter 0, latched code 0, codigo_out=0, ocupado=0, fim=0, rejeitado=0. Reset overrides everything, including mid-cycle.
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- Valid code: exactly one bit of codigo_in set. 4'b0000 and multi-hot codes are invalid.
- States:
  - OCIOSO:
    - iniciar=1 with a valid code at edge k: latch codigo_in, clear counter, go to ACESO.
    - iniciar=1 with an invalid code: stay in OCIOSO; rejeitado=1 during cycle k+1 only.
    - iniciar=0: stay.
  - ACESO:
    - codigo_out = latched code, ocupado=1.
    - Counter increments each cycle.
    - After T_ON cycles in ACESO (cycles k+1 .. k+T_ON), go to APAGADO if T_OFF>0, otherwise to FIM.
    - Counter clears on exit.
  - APAGADO:
    - codigo_out=0, ocupado=1.
    - Occupies cycles k+T_ON+1 .. k+T_ON+T_OFF, then go to FIM.
  - FIM:
    - Lasts exactly one cycle (k+T_ON+T_OFF+1): fim=1, ocupado=0, codigo_out=0.
    - Always returns to OCIOSO next cycle.
- iniciar is ignored in ACESO, APAGADO and FIM. A held iniciar is honoured again on the first OCIOSO cycle, so back-to-back moves have one idle cycle between fim and the next ACESO.
- codigo_in is only sampled at acceptance. Changes during ACESO do not affect codigo_out.
- Total latency from accepted iniciar to fim: T_ON+T_OFF+1 cycles.
- The counter never wraps: it is compared for equality with T_ON-1 or T_OFF-1 and cleared on every state exit.
- fim and rejeitado are never high in the same cycle. Neither is ever high for more than one cycle per event.
- Unreachable state encodings recover to OCIOSO on the next edge.

Test Plan:
Bench overrides T_ON=4, T_OFF=2.
- Reset then idle: hold reset 2 cycles, iniciar=0 -> codigo_out=0000, ocupado=0, fim=0, rejeitado=0 throughout.
- Single move: iniciar=1 for one cycle with codigo_in=0100 at edge 0 -> codigo_out=0100 on cycles 1-4; 0000 on cycles 5-6; fim=1 on cycle 7 only; ocupado=1 on cycles 1-6.
- Invalid code:
  - codigo_in=0110 with iniciar=1 -> rejeitado=1 for exactly one cycle, ocupado stays 0, codigo_out stays 0000.
  - Repeat with codigo_in=0000 -> same response.
- Input change and held start: start with 1000, switch codigo_in to 0001 on cycle 2 while holding iniciar=1 -> codigo_out stays 1000 through cycle 4, fim on cycle 7, OCIOSO on cycle 8, second display of 0001 on cycles 9-12.
- Reset mid-operation: assert reset on cycle 3 of ACESO -> next cycle codigo_out=0000, ocupado=0, no fim pulse; a fresh start afterwards gives full normal timing.
- T_OFF=0 variant: start with 0010 -> codigo_out=0010 on cycles 1-4, fim=1 on cycle 5, no blank cycles.
